// File: rtl/axil_sram_gen2_if.sv
// Channel bundle for axil_sram_gen2: read address/data and write address/data/response.
// The master modport is the requester side, the slave modport is the memory side.
interface axil_sram_gen2_if #(
  parameter int unsigned DATA_BYTES = 16
);
  logic [31:0]             readAddr_addr;
  logic                    readAddr_valid;
  logic                    readAddr_ready;
  logic [8*DATA_BYTES-1:0] readData_data;
  logic [1:0]              readData_resp;
  logic                    readData_valid;
  logic                    readData_ready;
  logic [31:0]             writeAddr_addr;
  logic                    writeAddr_valid;
  logic                    writeAddr_ready;
  logic [8*DATA_BYTES-1:0] writeData_data;
  logic [DATA_BYTES-1:0]   writeData_strb;
  logic                    writeData_valid;
  logic                    writeData_ready;
  logic [1:0]              writeResp_msg;
  logic                    writeResp_valid;
  logic                    writeResp_ready;

  modport master (
    output readAddr_addr, readAddr_valid, readData_ready,
    output writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb, writeData_valid,
    output writeResp_ready,
    input  readAddr_ready, readData_data, readData_resp, readData_valid,
    input  writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );

  modport slave (
    input  readAddr_addr, readAddr_valid, readData_ready,
    input  writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb, writeData_valid,
    input  writeResp_ready,
    output readAddr_ready, readData_data, readData_resp, readData_valid,
    output writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );
endinterface

// File: rtl/axil_sram_gen2.sv
// Byte-addressed SRAM behind an AXI-Lite style port with independent read and write FSMs.
// Beats wrap at the top of memory; addresses at or above LIMIT answer SLVERR.
module axil_sram_gen2 #(
  parameter int unsigned     DATA_BYTES = 16,
  parameter int unsigned     ADDR_W     = 16,
  parameter longint unsigned LIMIT      = 64'd1 << ADDR_W,
  parameter int unsigned     RD_LAT     = 1
) (
  input logic             clk,
  input logic             rst,
  axil_sram_gen2_if.slave bus
);
  localparam longint unsigned MemBytes = 64'd1 << ADDR_W;
  localparam int unsigned     DataW    = 8 * DATA_BYTES;
  // Last RWAIT count before moving to RRESP; unused when RD_LAT == 1.
  localparam logic [1:0]      LatLast  = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
  typedef enum logic [2:0] {WIdle, WWaitData, WWaitAddr, WWrite, WResp} wr_state_e;

  logic [7:0] mem [MemBytes];

  rd_state_e          rd_state_q, rd_state_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic [DataW-1:0]   rd_data_q, rd_data_d, rd_sample;
  logic [1:0]         rd_resp_q, rd_resp_d;
  logic               rd_err;

  wr_state_e             wr_state_q, wr_state_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic [DataW-1:0]      wr_data_q, wr_data_d;
  logic [DATA_BYTES-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]            wr_resp_q, wr_resp_d;
  logic                  aw_ready, w_ready, aw_fire, w_fire, wr_err;

  // Read path
  assign rd_err = {32'd0, bus.readAddr_addr} >= LIMIT;

  always_comb begin
    rd_sample = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_sample[8*i +: 8] = mem[ADDR_W'(bus.readAddr_addr[ADDR_W-1:0] + ADDR_W'(i))];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_data_d  = rd_data_q;
    rd_resp_d  = rd_resp_q;
    unique case (rd_state_q)
      RIdle: begin
        if (bus.readAddr_valid) begin
          rd_data_d  = rd_err ? '0 : rd_sample;
          rd_resp_d  = rd_err ? 2'b10 : 2'b00;
          rd_cnt_d   = '0;
          rd_state_d = (RD_LAT > 1) ? RWait : RResp;
        end
      end
      RWait: begin
        if (rd_cnt_q == LatLast) rd_state_d = RResp;
        else                     rd_cnt_d   = rd_cnt_q + 2'd1;
      end
      RResp: begin
        if (bus.readData_ready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RIdle;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_resp_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  assign bus.readAddr_ready = (rd_state_q == RIdle);
  assign bus.readData_valid = (rd_state_q == RResp);
  assign bus.readData_data  = rd_data_q;
  assign bus.readData_resp  = rd_resp_q;

  // Write path
  assign aw_ready = (wr_state_q == WIdle) || (wr_state_q == WWaitAddr);
  assign w_ready  = (wr_state_q == WIdle) || (wr_state_q == WWaitData);
  assign aw_fire  = bus.writeAddr_valid && aw_ready;
  assign w_fire   = bus.writeData_valid && w_ready;
  assign wr_err   = {32'd0, wr_addr_q} >= LIMIT;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    wr_resp_d  = wr_resp_q;
    if (aw_fire) wr_addr_d = bus.writeAddr_addr;
    if (w_fire) begin
      wr_data_d = bus.writeData_data;
      wr_strb_d = bus.writeData_strb;
    end
    unique case (wr_state_q)
      WIdle: begin
        if (aw_fire && w_fire) wr_state_d = WWrite;
        else if (aw_fire)      wr_state_d = WWaitData;
        else if (w_fire)       wr_state_d = WWaitAddr;
      end
      WWaitData: if (w_fire)  wr_state_d = WWrite;
      WWaitAddr: if (aw_fire) wr_state_d = WWrite;
      WWrite: begin
        wr_resp_d  = wr_err ? 2'b10 : 2'b00;
        wr_state_d = WResp;
      end
      WResp: if (bus.writeResp_ready) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WIdle;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_resp_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_resp_q  <= wr_resp_d;
    end
  end

  // Commit is non-blocking, so a read sampled in the same cycle still sees the old bytes.
  always_ff @(posedge clk) begin
    if (wr_state_q == WWrite && !wr_err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (wr_strb_q[i]) begin
          mem[ADDR_W'(wr_addr_q[ADDR_W-1:0] + ADDR_W'(i))] <= wr_data_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.writeAddr_ready = aw_ready;
  assign bus.writeData_ready = w_ready;
  assign bus.writeResp_valid = (wr_state_q == WResp);
  assign bus.writeResp_msg   = wr_resp_q;
endmodule

// File: tb/tb_axil_sram_gen2.sv
// Bench for axil_sram_gen2: two instances share stimulus (LIMIT 0x8000 and full range),
// expectations come from a byte model and are checked from scoreboards on each handshake.
module tb_axil_sram_gen2;
  localparam int unsigned     DB    = 16;
  localparam int unsigned     DW    = 8 * DB;
  localparam longint unsigned LIM_A = 64'h8000;
  localparam int unsigned     LAT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  axil_sram_gen2_if #(.DATA_BYTES(DB)) bus_a ();
  axil_sram_gen2_if #(.DATA_BYTES(DB)) bus_b ();

  assign bus_b.readAddr_addr   = bus_a.readAddr_addr;
  assign bus_b.readAddr_valid  = bus_a.readAddr_valid;
  assign bus_b.readData_ready  = bus_a.readData_ready;
  assign bus_b.writeAddr_addr  = bus_a.writeAddr_addr;
  assign bus_b.writeAddr_valid = bus_a.writeAddr_valid;
  assign bus_b.writeData_data  = bus_a.writeData_data;
  assign bus_b.writeData_strb  = bus_a.writeData_strb;
  assign bus_b.writeData_valid = bus_a.writeData_valid;
  assign bus_b.writeResp_ready = bus_a.writeResp_ready;

  axil_sram_gen2 #(
    .DATA_BYTES(DB), .ADDR_W(16), .LIMIT(LIM_A), .RD_LAT(LAT)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  axil_sram_gen2 #(
    .DATA_BYTES(DB), .ADDR_W(16), .LIMIT(64'h10000), .RD_LAT(LAT)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct packed {
    logic [DW-1:0] data_a;
    logic [1:0]    resp_a;
    logic [DW-1:0] data_b;
    logic [1:0]    resp_b;
  } rd_exp_t;

  typedef struct packed {
    logic [1:0] msg_a;
    logic [1:0] msg_b;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;

  logic [7:0] mdl_a [65536];
  logic [7:0] mdl_b [65536];

  function automatic logic [DW-1:0] fill(input logic [7:0] base, input logic [7:0] step);
    logic [DW-1:0] d;
    for (int i = 0; i < DB; i++) d[8*i +: 8] = base + step * 8'(i);
    return d;
  endfunction

  function automatic rd_exp_t predict_read(input logic [31:0] addr);
    rd_exp_t e;
    logic [15:0] idx;
    e = '0;
    for (int i = 0; i < DB; i++) begin
      idx = addr[15:0] + 16'(i);
      e.data_a[8*i +: 8] = mdl_a[idx];
      e.data_b[8*i +: 8] = mdl_b[idx];
    end
    if (64'(addr) >= LIM_A) begin
      e.data_a = '0;
      e.resp_a = 2'b10;
    end
    if (addr >= 32'h0001_0000) begin
      e.data_b = '0;
      e.resp_b = 2'b10;
    end
    return e;
  endfunction

  function automatic wr_exp_t model_write(input logic [31:0] addr, input logic [DW-1:0] data,
                                          input logic [DB-1:0] strb);
    wr_exp_t e;
    logic [15:0] idx;
    e.msg_a = (64'(addr) >= LIM_A) ? 2'b10 : 2'b00;
    e.msg_b = (addr >= 32'h0001_0000) ? 2'b10 : 2'b00;
    for (int i = 0; i < DB; i++) begin
      idx = addr[15:0] + 16'(i);
      if (strb[i] && e.msg_a == 2'b00) mdl_a[idx] = data[8*i +: 8];
      if (strb[i] && e.msg_b == 2'b00) mdl_b[idx] = data[8*i +: 8];
    end
    return e;
  endfunction

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus_a.readData_valid && bus_a.readData_ready) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%h want=no_beat", bus_a.readData_data);
      end else begin
        re = rd_q.pop_front();
        if ({bus_a.readData_resp, bus_a.readData_data} !== {re.resp_a, re.data_a}) begin
          failures++;
          $display("FAIL rd_beat_a got=%b/%h want=%b/%h", bus_a.readData_resp,
                   bus_a.readData_data, re.resp_a, re.data_a);
        end
        checks++;
        if ({bus_b.readData_valid, bus_b.readData_resp, bus_b.readData_data} !==
            {1'b1, re.resp_b, re.data_b}) begin
          failures++;
          $display("FAIL rd_beat_b got=%b/%b/%h want=1/%b/%h", bus_b.readData_valid,
                   bus_b.readData_resp, bus_b.readData_data, re.resp_b, re.data_b);
        end
      end
    end
    if (!rst && bus_a.writeResp_valid && bus_a.writeResp_ready) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got=%b want=no_resp", bus_a.writeResp_msg);
      end else begin
        we = wr_q.pop_front();
        if ({bus_a.writeResp_msg, bus_b.writeResp_valid, bus_b.writeResp_msg} !==
            {we.msg_a, 1'b1, we.msg_b}) begin
          failures++;
          $display("FAIL wr_resp got=a:%b b:%b/%b want=a:%b b:1/%b", bus_a.writeResp_msg,
                   bus_b.writeResp_valid, bus_b.writeResp_msg, we.msg_a, we.msg_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall);
    int n;
    logic [DW-1:0] held;
    bus_a.readAddr_addr  = addr;
    bus_a.readAddr_valid = 1'b1;
    n = 0;
    while (!bus_a.readAddr_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus_a.readAddr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_accept_timeout got=%b want=1", bus_a.readAddr_ready);
      bus_a.readAddr_valid = 1'b0;
      return;
    end
    rd_q.push_back(predict_read(addr));
    tick();
    bus_a.readAddr_valid = 1'b0;
    n = 1;
    while (!bus_a.readData_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL rd_latency got=%0d want=%0d", n, LAT);
    end
    held = bus_a.readData_data;
    for (int k = 0; k < stall; k++) begin
      tick();
      checks++;
      if ({bus_a.readData_valid, bus_a.readAddr_ready} !== 2'b10 ||
          bus_a.readData_data !== held) begin
        failures++;
        $display("FAIL rd_stall got=v%b ar%b %h want=v1 ar0 %h", bus_a.readData_valid,
                 bus_a.readAddr_ready, bus_a.readData_data, held);
      end
    end
    bus_a.readData_ready = 1'b1;
    tick();
    bus_a.readData_ready = 1'b0;
    checks++;
    if ({bus_a.readData_valid, bus_a.readAddr_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rd_release got=v%b ar%b want=v0 ar1", bus_a.readData_valid,
               bus_a.readAddr_ready);
    end
  endtask

  // mode 0: address and data together; 1: data leads by `lead`; 2: address leads by `lead`.
  task automatic do_write(input logic [31:0] addr, input logic [DW-1:0] data,
                          input logic [DB-1:0] strb, input int mode, input int lead);
    int n;
    bus_a.writeAddr_addr = addr;
    bus_a.writeData_data = data;
    bus_a.writeData_strb = strb;
    checks++;
    if ({bus_a.writeAddr_ready, bus_a.writeData_ready} !== 2'b11) begin
      failures++;
      $display("FAIL wr_idle_ready got=%b want=11",
               {bus_a.writeAddr_ready, bus_a.writeData_ready});
    end
    if (mode == 0) begin
      bus_a.writeAddr_valid = 1'b1;
      bus_a.writeData_valid = 1'b1;
      tick();
    end else begin
      if (mode == 1) bus_a.writeData_valid = 1'b1;
      else           bus_a.writeAddr_valid = 1'b1;
      tick();
      bus_a.writeAddr_valid = 1'b0;
      bus_a.writeData_valid = 1'b0;
      for (int k = 0; k < lead; k++) begin
        checks++;
        if ({bus_a.writeAddr_ready, bus_a.writeData_ready} !== ((mode == 1) ? 2'b10 : 2'b01))
        begin
          failures++;
          $display("FAIL wr_wait_ready got=%b want=%b",
                   {bus_a.writeAddr_ready, bus_a.writeData_ready},
                   (mode == 1) ? 2'b10 : 2'b01);
        end
        if (k == lead - 1) begin
          if (mode == 1) bus_a.writeAddr_valid = 1'b1;
          else           bus_a.writeData_valid = 1'b1;
        end
        tick();
      end
    end
    bus_a.writeAddr_valid = 1'b0;
    bus_a.writeData_valid = 1'b0;
    wr_q.push_back(model_write(addr, data, strb));
    n = 0;
    while (!bus_a.writeResp_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL wr_resp_latency got=%0d want=1", n);
    end
    bus_a.writeResp_ready = 1'b1;
    tick();
    bus_a.writeResp_ready = 1'b0;
    checks++;
    if ({bus_a.writeResp_valid, bus_a.writeAddr_ready, bus_a.writeData_ready} !== 3'b011) begin
      failures++;
      $display("FAIL wr_release got=%b want=011",
               {bus_a.writeResp_valid, bus_a.writeAddr_ready, bus_a.writeData_ready});
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if ({bus_a.readAddr_ready, bus_a.writeAddr_ready, bus_a.writeData_ready,
         bus_a.readData_valid, bus_a.writeResp_valid, bus_a.readData_resp,
         bus_a.writeResp_msg} !== 9'b111_00_00_00 || bus_a.readData_data !== '0) begin
      failures++;
      $display("FAIL rst_during got=%b %h want=111000000 0", {bus_a.readAddr_ready,
               bus_a.writeAddr_ready, bus_a.writeData_ready, bus_a.readData_valid,
               bus_a.writeResp_valid, bus_a.readData_resp, bus_a.writeResp_msg},
               bus_a.readData_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++;
    if ({bus_a.readAddr_ready, bus_a.writeAddr_ready, bus_a.writeData_ready,
         bus_a.readData_valid, bus_a.writeResp_valid, bus_a.readData_resp,
         bus_a.writeResp_msg} !== 9'b111_00_00_00 || bus_a.readData_data !== '0) begin
      failures++;
      $display("FAIL rst_after got=%b %h want=111000000 0", {bus_a.readAddr_ready,
               bus_a.writeAddr_ready, bus_a.writeData_ready, bus_a.readData_valid,
               bus_a.writeResp_valid, bus_a.readData_resp, bus_a.writeResp_msg},
               bus_a.readData_data);
    end
  endtask

  task automatic test_write_read_basic();
    do_write(32'h0010, fill(8'h00, 8'h01), '1, 0, 1);
    do_read(32'h0010, 0);
  endtask

  task automatic test_partial_strobe();
    do_write(32'h0100, '0, '1, 0, 1);
    do_write(32'h0100, fill(8'hFF, 8'h00), 16'h00F0, 1, 2);
    do_read(32'h0100, 0);
    do_write(32'h0100, fill(8'h12, 8'h01), 16'h0000, 2, 3);
    do_read(32'h0100, 0);
  endtask

  task automatic test_wrap();
    do_write(32'h0000, '0, '1, 0, 1);
    do_write(32'hFFF8, fill(8'hA0, 8'h01), '1, 2, 1);
    do_read(32'hFFF8, 0);
    do_read(32'h0000, 0);
  endtask

  task automatic test_limit();
    do_write(32'h1000, fill(8'h5A, 8'h00), '1, 0, 1);
    do_write(32'h9000, fill(8'hC3, 8'h01), '1, 0, 1);
    do_read(32'h9000, 0);
    do_write(32'h0001_1000, fill(8'hEE, 8'h00), '1, 1, 1);
    do_read(32'h1000, 0);
    do_read(32'h0001_1000, 0);
  endtask

  task automatic test_stall();
    do_read(32'h0010, 5);
  endtask

  task automatic test_collision();
    int n;
    do_write(32'h0400, fill(8'h33, 8'h00), '1, 0, 1);
    bus_a.writeAddr_addr  = 32'h0404;
    bus_a.writeData_data  = fill(8'h77, 8'h00);
    bus_a.writeData_strb  = '1;
    bus_a.writeAddr_valid = 1'b1;
    bus_a.writeData_valid = 1'b1;
    tick();
    bus_a.writeAddr_valid = 1'b0;
    bus_a.writeData_valid = 1'b0;
    bus_a.readAddr_addr   = 32'h0400;
    bus_a.readAddr_valid  = 1'b1;
    checks++;
    if (bus_a.readAddr_ready !== 1'b1) begin
      failures++;
      $display("FAIL coll_rd_ready got=%b want=1", bus_a.readAddr_ready);
    end
    rd_q.push_back(predict_read(32'h0400));
    tick();
    bus_a.readAddr_valid = 1'b0;
    wr_q.push_back(model_write(32'h0404, fill(8'h77, 8'h00), '1));
    checks++;
    if (bus_a.writeResp_valid !== 1'b1) begin
      failures++;
      $display("FAIL coll_wr_valid got=%b want=1", bus_a.writeResp_valid);
    end
    bus_a.writeResp_ready = 1'b1;
    n = 1;
    while (!bus_a.readData_valid && n < 50) begin
      tick();
      bus_a.writeResp_ready = 1'b0;
      n++;
    end
    bus_a.writeResp_ready = 1'b0;
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL coll_rd_latency got=%0d want=%0d", n, LAT);
    end
    bus_a.readData_ready = 1'b1;
    tick();
    bus_a.readData_ready = 1'b0;
    do_read(32'h0400, 0);
  endtask

  task automatic test_abort();
    do_write(32'h0200, fill(8'hAA, 8'h00), '1, 0, 1);
    do_write(32'h0300, fill(8'h55, 8'h00), '1, 0, 1);
    bus_a.writeAddr_addr  = 32'h0200;
    bus_a.writeData_data  = fill(8'hFF, 8'h00);
    bus_a.writeData_strb  = '1;
    bus_a.writeAddr_valid = 1'b1;
    tick();
    bus_a.writeAddr_valid = 1'b0;
    checks++;
    if ({bus_a.writeAddr_ready, bus_a.writeData_ready} !== 2'b01) begin
      failures++;
      $display("FAIL abort_waitwdata got=%b want=01",
               {bus_a.writeAddr_ready, bus_a.writeData_ready});
    end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    do_write(32'h0300, fill(8'h11, 8'h00), '1, 1, 1);
    do_read(32'h0200, 0);
    do_read(32'h0300, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic [DB-1:0] strb;
    for (int k = 0; k < 18; k++) do_write(32'h2000 + 32'(16 * k), '0, '1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      addr = 32'h2000 + $urandom_range(0, 255);
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      strb = 16'($urandom());
      do_write(addr, data, strb, k % 3, 1 + k % 3);
      do_read(32'h2000 + $urandom_range(0, 255), k % 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.readAddr_addr   = '0;
    bus_a.readAddr_valid  = 1'b0;
    bus_a.readData_ready  = 1'b0;
    bus_a.writeAddr_addr  = '0;
    bus_a.writeAddr_valid = 1'b0;
    bus_a.writeData_data  = '0;
    bus_a.writeData_strb  = '0;
    bus_a.writeData_valid = 1'b0;
    bus_a.writeResp_ready = 1'b0;
    test_reset();
    test_write_read_basic();
    test_partial_strobe();
    test_wrap();
    test_limit();
    test_stall();
    test_collision();
    test_abort();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=rd%0d wr%0d want=rd0 wr0", rd_q.size(), wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
